// File: rtl/imm_pack.sv
// Immediate encoder/packer for the RISC-V instruction loader path, with a 2-entry output queue.
// Optional range/alignment checking and RUN/HALT error handling are enabled by IMM_PACK_CHECK_EN.
module imm_pack #(
  parameter bit HALT_ON_ERR = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  immsrc,
  input  logic [31:0] imm,
  input  logic [31:0] base,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_err,
  output logic        halted,
  input  logic        clr,
  output logic [7:0]  err_cnt
);

  localparam int unsigned IW = 32;
  localparam int unsigned CW = 8;

  typedef enum logic {S_RUN, S_HALT} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   pack_c;
  logic            err_c;
  logic            tail_v;
  logic [IW-1:0]   tail_instr;
  logic            tail_err;
  logic            push, pop, err_acc;

  // Scatter the immediate into the type's field positions; other bits pass through from base
  always_comb begin
    pack_c = base;
    case (immsrc)
      2'b00: pack_c = {imm[11:0], base[19:0]};
      2'b01: pack_c = {imm[11:5], base[24:12], imm[4:0], base[6:0]};
      2'b10: pack_c = {imm[12], imm[10:5], base[24:12], imm[4:1], imm[11], base[6:0]};
      2'b11: pack_c = {imm[20], imm[10:1], imm[11], imm[19:12], base[11:0]};
      default: pack_c = base;
    endcase
  end

`ifdef IMM_PACK_CHECK_EN
  logic range_c, align_c;

  // Bits above the field's sign bit must all equal it
  always_comb begin
    range_c = 1'b0;
    case (immsrc)
      2'b00, 2'b01: range_c = !((&imm[31:11]) || (~|imm[31:11]));
      2'b10:        range_c = !((&imm[31:12]) || (~|imm[31:12]));
      2'b11:        range_c = !((&imm[31:20]) || (~|imm[31:20]));
      default:      range_c = 1'b0;
    endcase
  end

  assign align_c = immsrc[1] & imm[0];
  assign err_c   = range_c | align_c;
`else
  logic unused_imm;

  assign unused_imm = ^imm[31:21];
  assign err_c      = 1'b0;
`endif

  assign in_ready = !(out_valid && tail_v) && (state_q == S_RUN);
  assign halted   = (state_q == S_HALT);
  assign push     = in_valid && in_ready;
  assign pop      = out_valid && out_ready;
  assign err_acc  = push && err_c;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_RUN;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN:  if (err_acc && HALT_ON_ERR) state_d = S_HALT;
      S_HALT: if (clr) state_d = S_RUN;
      default: state_d = S_RUN;
    endcase
  end

  // clr wins over the old count, but a same-cycle erroring accept still counts
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_cnt <= '0;
    end else if (clr) begin
      err_cnt <= err_acc ? CW'(1) : CW'(0);
    end else if (err_acc && (err_cnt != {CW{1'b1}})) begin
      err_cnt <= err_cnt + CW'(1);
    end
  end

  // Head register drives the outputs directly; tail holds the second entry
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid  <= 1'b0;
      out_instr  <= '0;
      out_err    <= 1'b0;
      tail_v     <= 1'b0;
      tail_instr <= '0;
      tail_err   <= 1'b0;
    end else if (pop) begin
      if (tail_v) begin
        out_instr <= tail_instr;
        out_err   <= tail_err;
        tail_v    <= 1'b0;
      end else begin
        out_valid <= push;
        if (push) begin
          out_instr <= pack_c;
          out_err   <= err_c;
        end
      end
    end else if (push) begin
      if (!out_valid) begin
        out_valid <= 1'b1;
        out_instr <= pack_c;
        out_err   <= err_c;
      end else begin
        tail_v     <= 1'b1;
        tail_instr <= pack_c;
        tail_err   <= err_c;
      end
    end
  end

endmodule

// File: doc/imm_pack.md
# imm_pack

Immediate encoder and instruction packer for the single-cycle RISC-V core's instruction loader path. It takes a base instruction word, a 32-bit signed immediate and an immsrc type code, and scatters the immediate into the I/S/B/J bit positions; it is the exact inverse of the core's immediate extender. Results pass through a 2-entry output queue with a valid/ready handshake, and optional range and alignment checking drives a RUN/HALT error state machine. It sits between the boot/test-program generator and the instruction-memory write port.

## Interface
- HALT_ON_ERR, 1, when 1 an accepted erroring beat sends the FSM to HALT; when 0 errors are only flagged and counted
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid && in_ready
- immsrc  in  2  00 I, 01 S, 10 B, 11 J (same encoding as the extender)
- imm  in  32  signed immediate (byte offset for B/J)
- base  in  32  opcode/funct/register fields; its immediate-field bits are overwritten
- out_valid  out  1  output beat valid
- out_ready  in  1  output beat consumed when out_valid && out_ready
- out_instr  out  32  packed instruction
- out_err  out  1  sideband: this beat failed range/alignment check
- halted  out  1  FSM in HALT
- clr  in  1  single-cycle pulse: HALT->RUN, clears err_cnt
- err_cnt  out  8  accepted erroring beats, saturating at 255

## Operation
- Packing (only immediate-field bits are replaced; all other bits come from base):
  - I: [31:20]=imm[11:0].
  - S: [31:25]=imm[11:5], [11:7]=imm[4:0].
  - B: [31]=imm[12], [7]=imm[11], [30:25]=imm[10:5], [11:8]=imm[4:1].
  - J: [31]=imm[20], [19:12]=imm[19:12], [20]=imm[11], [30:21]=imm[10:1].
- Checks (macro-gated):
  - range error if imm[31:N-1] are not all equal, with N=12 (I/S), 13 (B), 21 (J).
  - alignment error if imm[0]=1 for B/J.
  - out_err = range || align.
- Queue: 2-entry FIFO of {instr, err}. in_ready = !full && state==RUN.
- FSM states: RUN, HALT.
  - RUN->HALT: an erroring beat is accepted and HALT_ON_ERR=1.
  - HALT->RUN: clr.
  - While in HALT, in_ready=0 and the queue keeps draining.
- err_cnt:
  - +1 per accepted erroring beat, holding at 255.
  - clr zeroes it. If clr and an erroring accept occur in the same cycle, the result is 1 and the accept's transition wins (HALT when HALT_ON_ERR=1).
- Packed-bit invariant: when out_err=0, extend(out_instr, immsrc) == imm.

## Timing
- Reset values: out_valid=0, out_instr=0, out_err=0, halted=0, err_cnt=0, FSM=RUN, queue empty. in_ready=1 (derived from the reset state).
- Latency: a beat accepted at edge t is visible on out_instr/out_valid after edge t, i.e. in cycle t+1.
- Throughput: 1 beat/cycle sustained while out_ready=1.
- Queue full (2 entries, out_ready=0): in_ready=0 in the same cycle.
- Simultaneous push and pop when full: not allowed, because in_ready=0 while full. When holding 1 entry, a push and a pop in the same cycle keep the occupancy at 1.
- Output stability: out_instr and out_err are held stable while out_valid && !out_ready.
- halted and in_ready reflect HALT from the cycle after the erroring accept. The beat after the erroring one is not accepted.
- After clr in HALT: in_ready rises the following cycle, provided the queue is not full.
- Reset mid-operation: the queue is flushed, out_valid drops immediately (asynchronously), and the FSM returns to RUN.

## Configuration
- IMM_PACK_CHECK_EN defined:
  - range and alignment checks are active.
  - out_err, err_cnt and the HALT state operate as described above.
- IMM_PACK_CHECK_EN undefined:
  - no checks: out_err=0, err_cnt=0, halted=0, and the FSM never leaves RUN.
  - out-of-range imm bits are silently truncated; imm[0] is dropped for B/J.

## Test plan
- Basic I pack: I type, base=32'h00000013, imm=-1 -> out_instr=32'hFFF00013, out_err=0, one cycle after accept.
- Round-trip J: J type, base=32'h0000006F, imm=32'h000FF7FE -> extend(out_instr)==imm. Sweep all four types with random in-range imm and check round-trip.
- Error and halt: B type, imm=32'h00001001 (odd offset), HALT_ON_ERR=1, with IMM_PACK_CHECK_EN defined -> out_err=1, err_cnt=1, halted=1, in_ready=0. Then clr -> halted=0, err_cnt=0, in_ready=1 on the next cycle.
- Backpressure: out_ready=0, push 3 beats -> only 2 are accepted and in_ready=0. Release out_ready -> 2 beats drain in order, then the third is accepted.
- Saturation: 300 erroring beats with HALT_ON_ERR=0 -> err_cnt=255, halted stays 0.
- Async reset mid-stream: reset_n low while the queue holds 2 beats -> out_valid=0 immediately. After release, in_ready=1 and no stale beats appear.
